// File: rtl/sort_seq_ctrl_pkg.sv
// Shared encodings and sizing helpers for the sequential bubble-sort controller.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index/pass counters cover N up to 8 (largest index N-2 = 6).
  localparam int IW = 3;

  function automatic int swap_cnt_w(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

  localparam int SCW = swap_cnt_w(4);

  // Last compare index of a pass: later passes stop earlier since the tail is already in place.
  function automatic logic [IW-1:0] last_idx(input int n, input logic [IW-1:0] pass);
    return IW'(n - 2) - pass;
  endfunction

endpackage

// File: rtl/sort_seq_ctrl_if.sv
// Producer/consumer side of the sort controller: start/din in, status and sorted data out.
interface sort_seq_ctrl_if import sort_pkg::*; #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int SCW_L = swap_cnt_w(N);

  logic             start;
  logic [N*W-1:0]   din;
  logic             busy;
  logic             done;
  logic [N*W-1:0]   dout;
  logic [SCW_L-1:0] swaps;

  modport master (output start, output din, input busy, input done, input dout, input swaps);
  modport slave  (input start, input din, output busy, output done, output dout, output swaps);
endinterface

// File: rtl/sort_seq_ctrl_cmp.sv
// 4-bit magnitude comparator shared by the sort sequencer.
module sort_seq_ctrl_cmp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       agb,
  output logic       alb,
  output logic       aeb
);
  assign agb = (a > b);
  assign alb = (a < b);
  assign aeb = (a == b);
endmodule

// File: rtl/sort_seq_ctrl.sv
// In-place bubble sort of N 4-bit elements, one compare-and-swap per clock,
// with early exit when a pass makes no swap.
module sort_seq_ctrl import sort_pkg::*; #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  sort_seq_ctrl_if.slave bus
);
  localparam int SCW_L = swap_cnt_w(N);

  state_e           state_r;
  logic [W-1:0]     elem_r [N];
  logic [IW-1:0]    idx_r;
  logic [IW-1:0]    pass_r;
  logic [SCW_L-1:0] swaps_r;
  logic             pass_swapped_r;
  logic             busy_r;
  logic             done_r;

  logic [W-1:0]     a_s;
  logic [W-1:0]     b_s;
  logic             agb_s;
  logic             alb_s;
  logic             aeb_s;
  logic             swap_s;
  logic             end_pass_s;
  logic             any_swap_s;
  logic [N*W-1:0]   dout_s;

  // Operand mux: comparator sees the adjacent pair at idx.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < N; i++) begin
      a_s = (idx_r == IW'(i)) ? elem_r[i] : a_s;
      b_s = ((idx_r + IW'(1)) == IW'(i)) ? elem_r[i] : b_s;
    end
  end

  sort_seq_ctrl_cmp u_cmp (
    .a   (a_s),
    .b   (b_s),
    .agb (agb_s),
    .alb (alb_s),
    .aeb (aeb_s)
  );

  // Swap only on a clean strictly-greater result; equal never swaps, keeping the sort stable.
  assign swap_s     = agb_s & ~(alb_s | aeb_s);
  assign end_pass_s = (idx_r == last_idx(N, pass_r));
  assign any_swap_s = pass_swapped_r | swap_s;

  // Sequencer FSM with element register file and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      idx_r          <= '0;
      pass_r         <= '0;
      swaps_r        <= '0;
      pass_swapped_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      for (int i = 0; i < N; i++) elem_r[i] <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            for (int i = 0; i < N; i++) elem_r[i] <= bus.din[i*W +: W];
            idx_r          <= '0;
            pass_r         <= '0;
            swaps_r        <= '0;
            pass_swapped_r <= 1'b0;
            busy_r         <= 1'b1;
            state_r        <= CMP;
          end
        end
        CMP: begin
          if (swap_s) begin
            for (int i = 0; i < N; i++) begin
              if (idx_r == IW'(i)) begin
                elem_r[i] <= b_s;
              end else if ((idx_r + IW'(1)) == IW'(i)) begin
                elem_r[i] <= a_s;
              end
            end
            swaps_r <= swaps_r + SCW_L'(1);
          end
          if (end_pass_s) begin
            if (!any_swap_s || (pass_r == IW'(N - 2))) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              pass_r         <= pass_r + IW'(1);
              idx_r          <= '0;
              pass_swapped_r <= 1'b0;
            end
          end else begin
            idx_r          <= idx_r + IW'(1);
            pass_swapped_r <= any_swap_s;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Flatten the element registers onto the output bus, element 0 in the low bits.
  always_comb begin
    dout_s = '0;
    for (int i = 0; i < N; i++) dout_s[i*W +: W] = elem_r[i];
  end

  assign bus.dout  = dout_s;
  assign bus.swaps = swaps_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl (N=4): reset, typical/sorted/equal/reverse sorts, start handling.
module tb_sort_seq_ctrl;
  logic clk;
  logic rst;
  int   checks_total;
  int   checks_passed;
  int   cyc;

  sort_seq_ctrl_if #(.N(4), .W(4)) bus ();

  sort_seq_ctrl #(.N(4), .W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total = checks_total + 1;
    if (got === exp) checks_passed = checks_passed + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one sort; with poke set, also pulse start (with junk din) during CMP and during DONE.
  task automatic sort_run(input string tag, input logic [15:0] din_v, input int exp_c,
                          input logic [15:0] exp_dout, input int exp_sw, input bit poke);
    int n;
    @(negedge clk);
    bus.din   = din_v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 50) begin
      if (bus.busy) n = n + 1;
      if (poke) begin
        bus.start = (n == 2);
        bus.din   = (n == 2) ? 16'h1111 : din_v;
      end
      step();
    end
    bus.start = 1'b0;
    check({tag, "_done"},   32'(bus.done), 32'd1);
    check({tag, "_cycles"}, 32'(n), 32'(exp_c));
    check({tag, "_dout"},   32'(bus.dout), 32'(exp_dout));
    check({tag, "_swaps"},  32'(bus.swaps), 32'(exp_sw));
    if (poke) begin
      bus.start = 1'b1;
      bus.din   = 16'h2222;
    end
    step();
    bus.start = 1'b0;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"},       32'(bus.dout), 32'(exp_dout));
    step();
    check({tag, "_idle"},       32'(bus.busy), 32'd0);
    check({tag, "_hold2"},      32'(bus.dout), 32'(exp_dout));
  endtask

  initial begin
    int t1;
    int t2;
    int n;
    checks_total  = 0;
    checks_passed = 0;
    cyc       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.din   = 16'h0000;
    step();
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_dout",  32'(bus.dout), 32'd0);
    check("rst_swaps", 32'(bus.swaps), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-sort
    bus.din   = 16'h7F9A;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",  32'(bus.busy), 32'd0);
    check("mid_rst_dout",  32'(bus.dout), 32'd0);
    check("mid_rst_swaps", 32'(bus.swaps), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    step();
    check("no_autostart", 32'(bus.busy), 32'd0);

    sort_run("typical", 16'h7F9A, 6, 16'hFA97, 4, 1'b0);
    sort_run("sorted",  16'h4321, 3, 16'h4321, 0, 1'b0);
    sort_run("equal",   16'h7777, 3, 16'h7777, 0, 1'b0);
    sort_run("reverse", 16'h35CF, 6, 16'hFC53, 6, 1'b0);
    sort_run("poke",    16'h35CF, 6, 16'hFC53, 6, 1'b1);

    // Back-to-back with start held: done every C+2 = 8 cycles
    @(negedge clk);
    bus.din   = 16'h7F9A;
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < 40) begin step(); n = n + 1; end
    t1 = cyc;
    check("b2b_first", 32'(bus.done), 32'd1);
    step();
    n = 0;
    while (!bus.done && n < 40) begin step(); n = n + 1; end
    t2 = cyc;
    bus.start = 1'b0;
    check("b2b_second", 32'(bus.done), 32'd1);
    check("b2b_period", 32'(t2 - t1), 32'd8);
    check("b2b_dout",   32'(bus.dout), 32'hFA97);
    check("b2b_swaps",  32'(bus.swaps), 32'd4);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/sort_seq_ctrl.md
# sort_seq_ctrl

Sequencing controller that sorts N 4-bit values in ascending order by time-sharing a single instance of the team's 4-bit magnitude comparator (outputs agb/alb/aeb). It performs an in-place bubble sort, one compare-and-conditional-swap per clock, and exits early when a pass makes no swap. It sits between a parallel-load producer and any consumer that needs ordered operands, and also reports the number of swaps performed.

## Interface
- N, 4, number of elements; legal range 2..8.
- W, 4, element width; fixed at 4 to match the shared comparator.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to capture din and sort; honoured only in IDLE.
- din  in  N*W  unsorted input; element i is din[i*W +: W].
- busy  out  1  high while in CMP.
- done  out  1  one-cycle pulse in DONE; dout is final.
- dout  out  N*W  element registers; element 0 is the smallest when done is high.
- swaps  out  SCW  swaps in the last sort; SCW = clog2(N*(N-1)/2 + 1), which is 3 for N=4.

## Operation
- States: IDLE, CMP, DONE.
- IDLE:
  - start=1 loads din into the element registers and clears idx, pass, swaps and pass_swapped.
  - The state then moves to CMP.
- CMP: each cycle the comparator sees A=elem[idx] and B=elem[idx+1].
  - If agb=1, elem[idx] and elem[idx+1] swap, swaps increments and pass_swapped is set.
  - If alb=1 or aeb=1, nothing changes. Equal values never swap, so the sort is stable.
- End of pass: idx = N-2-pass.
  - If pass_swapped=0 (including this cycle's swap) or pass = N-2, go to DONE.
  - Otherwise increment pass, clear idx and pass_swapped, and stay in CMP.
  - Before the end of a pass, idx increments each cycle.
- DONE: done=1 for one cycle, then the state returns to IDLE.
- start outside IDLE is ignored, with no queuing. That includes start in the DONE cycle.
- After DONE, dout and swaps hold their values until the next accepted start.
- rst (asynchronous, any time, including mid-sort):
  - State goes to IDLE.
  - Element registers, idx, pass, swaps and pass_swapped all go to 0.
- Reset values: busy=0, done=0, dout=0, swaps=0.

## Timing
- start is sampled on edge k. CMP occupies cycles k+1 through k+C, where C is the number of compares. done is high in cycle k+C+1.
- C ranges from N-1 (input already sorted) to N*(N-1)/2 (worst case). For N=4, C is 3..6.
- A swap is visible on dout on the edge that ends that compare cycle.
- The comparator is purely combinational, so one compare completes per cycle with no pipeline stall.
- dout may change every cycle while busy=1. It is stable whenever busy=0.
- Back-to-back sorts: start held continuously is accepted in IDLE, the cycle after DONE. Minimum period per sort is C+2 cycles.

## Structure
- Shared package sort_pkg holds:
  - state encodings IDLE=2'd0, CMP=2'd1, DONE=2'd2;
  - the SCW width constant;
  - the per-pass last-index expression N-2-pass.
- Sub-module: the existing comparator, instantiated once. Its inputs are driven by a mux over elem[idx] and elem[idx+1].
- The element register file and swap logic stay in sort_seq_ctrl.

## Test plan
- Reset defaults: assert rst mid-sort with N=4 and din=[10,9,15,7].
  - Immediately: busy=0, dout=0, swaps=0, state IDLE.
  - After release, start is required to begin a new sort.
- Typical sort: din=[10,9,15,7] (element 0 first), start.
  - 6 CMP cycles, then done.
  - dout=[7,9,10,15], swaps=4.
- Already sorted: din=[1,2,3,4].
  - Early exit after 3 CMP cycles.
  - dout=[1,2,3,4], swaps=0.
- All equal: din=[7,7,7,7].
  - 3 CMP cycles, swaps=0; no swap on aeb.
- Reverse order: din=[15,12,5,3].
  - 6 CMP cycles.
  - dout=[3,5,12,15], swaps=6 (maximum).
- Start handling:
  - start pulsed during CMP and during DONE is ignored, and dout is unaffected.
  - start held high continuously gives consecutive sorts with done spaced C+2 cycles apart.
